nfc_cmd_arbiter: RTL and testbench

Round-robin command scheduler that shares the single NAND flash controller (NFC) between up to `NREQ` requesters. Each requester submits 33-bit NFC commands over a valid/ready handshake into its own one-deep holding register. The arbiter gates the NFC's command input until the controller's power-up flash reset completes. It then issues one command at a time, holds it stable until the NFC `done` pulse, and returns a per-port completion pulse. A watchdog halts issue if the NFC never completes.

---
 rtl/nfc_cmd_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_nfc_cmd_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nfc_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// nfc_cmd_arbiter
//
// Round-robin command scheduler sharing one NAND flash controller (NFC)
// between NREQ requesters. Each requester owns a one-deep holding register
// filled over a valid/ready handshake. Nothing is issued to the NFC until its
// power-up flash reset completes (first nfc_done). After that, one command is
// issued at a time and held stable until nfc_done, which returns a one-cycle
// completion pulse to the granted port. A watchdog halts issue permanently
// (until rst) if the NFC never completes a command.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   req_valid[i]    port i command valid
//   req_ready[i]    port i may load its holding register (~pend & ~halted)
//   req_cmd         port i command at bits [33i+32:33i]
//                   format {rw, faddr[17:0], maddr[6:0], len[6:0]}
//   rsp_done[i]     one-cycle completion pulse for the served port
//   nfc_cmd         command presented to the NFC (holds last issued value)
//   nfc_cmd_valid   qualifies nfc_cmd; NFC idles while low
//   nfc_done        NFC completion pulse (first one ends power-up reset)
//   grant_id        port being served (meaningful while busy)
//   busy            a command is outstanding at the NFC
//   init_done       NFC power-up reset has completed
//   timeout_err     sticky watchdog expiry flag
// -----------------------------------------------------------------------------
module nfc_cmd_arbiter #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 1048576,
   parameter int TW      = 20
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [NREQ*33-1:0]      req_cmd,
   output logic [NREQ-1:0]         rsp_done,
   output logic [32:0]             nfc_cmd,
   output logic                    nfc_cmd_valid,
   input  logic                    nfc_done,
   output logic [$clog2(NREQ)-1:0] grant_id,
   output logic                    busy,
   output logic                    init_done,
   output logic                    timeout_err
);

   localparam int GW = $clog2(NREQ);
   localparam int CW = 33;
   localparam logic [TW-1:0] WDOG_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_INIT, S_IDLE, S_BUSY, S_HALT} state_t;

   state_t          state_q, state_d;
   logic [NREQ-1:0] pend_q, pend_d;
   logic [CW-1:0]   hold_q [NREQ];
   logic [GW-1:0]   ptr_q, ptr_d;
   logic [GW-1:0]   grant_q, grant_d;
   logic [TW-1:0]   wdog_q, wdog_d;
   logic [CW-1:0]   cmd_q, cmd_d;
   logic            vld_q, vld_d;
   logic [NREQ-1:0] rsp_q, rsp_d;
   logic            init_q, init_d;
   logic            terr_q, terr_d;
   logic            busy_q, busy_d;

   logic            halted;
   logic [NREQ-1:0] accept;
   logic            found;
   logic [GW-1:0]   sel;

   assign halted    = (state_q == S_HALT);
   assign req_ready = ~pend_q & {NREQ{~halted}};
   assign accept    = req_valid & req_ready;

   // Round-robin search: first pending port in the order ptr, ptr+1, ...
   // wrapping at NREQ (which need not be a power of two).
   always_comb begin
      int idx;
      logic [GW-1:0] cand;
      found = 1'b0;
      sel   = '0;
      idx   = 0;
      cand  = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         cand = GW'(idx);
         if (!found && pend_q[cand]) begin
            found = 1'b1;
            sel   = cand;
         end
      end
   end

   // State register and all control/output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_INIT;
         pend_q  <= '0;
         ptr_q   <= '0;
         grant_q <= '0;
         wdog_q  <= '0;
         cmd_q   <= '0;
         vld_q   <= 1'b0;
         rsp_q   <= '0;
         init_q  <= 1'b0;
         terr_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         wdog_q  <= wdog_d;
         cmd_q   <= cmd_d;
         vld_q   <= vld_d;
         rsp_q   <= rsp_d;
         init_q  <= init_d;
         terr_q  <= terr_d;
         busy_q  <= busy_d;
      end
   end

   // Holding registers are pure data: qualified by pend, so no reset needed
   always_ff @(posedge clk) begin
      for (int i = 0; i < NREQ; i++) begin
         if (accept[i]) hold_q[i] <= req_cmd[i*CW +: CW];
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_INIT:  if (nfc_done) state_d = S_IDLE;
         S_IDLE:  if (found) state_d = S_BUSY;
         S_BUSY: begin
            // Completion wins over a simultaneous watchdog expiry
            if (nfc_done)                  state_d = S_IDLE;
            else if (wdog_q == WDOG_LAST)  state_d = S_HALT;
         end
         default: state_d = S_HALT;
      endcase
   end

   // Output / datapath next values
   always_comb begin
      pend_d  = pend_q | accept;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      wdog_d  = wdog_q;
      cmd_d   = cmd_q;
      vld_d   = vld_q;
      rsp_d   = '0;
      init_d  = init_q;
      terr_d  = terr_q;
      case (state_q)
         S_INIT: begin
            if (nfc_done) init_d = 1'b1;
         end
         S_IDLE: begin
            if (found) begin
               cmd_d   = hold_q[sel];
               vld_d   = 1'b1;
               grant_d = sel;
               wdog_d  = '0;
            end
         end
         S_BUSY: begin
            wdog_d = wdog_q + TW'(1);
            if (nfc_done) begin
               vld_d          = 1'b0;
               pend_d[grant_q] = 1'b0;
               rsp_d[grant_q]  = 1'b1;
               ptr_d = (grant_q == GW'(NREQ - 1)) ? '0 : grant_q + GW'(1);
            end else if (wdog_q == WDOG_LAST) begin
               terr_d = 1'b1;
               vld_d  = 1'b0;
            end
         end
         default: begin
            vld_d = 1'b0;
         end
      endcase
      busy_d = (state_d == S_BUSY);
   end

   assign rsp_done      = rsp_q;
   assign nfc_cmd       = cmd_q;
   assign nfc_cmd_valid = vld_q;
   assign grant_id      = grant_q;
   assign busy          = busy_q;
   assign init_done     = init_q;
   assign timeout_err   = terr_q;

endmodule

// File: tb/tb_nfc_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_nfc_cmd_arbiter
//
// Directed bench for nfc_cmd_arbiter. Instance dut_a uses the default
// watchdog limit; dut_w shares all inputs but uses TIMEOUT = 16 so the
// watchdog scenarios fit in a short run. Expected grants are pushed to a
// scoreboard queue when commands are submitted and popped when dut_a issues.
// -----------------------------------------------------------------------------
module tb_nfc_cmd_arbiter;

   typedef struct packed {
      logic [1:0]  port;
      logic [32:0] cmd;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [3:0]    req_valid;
   logic [131:0]  req_cmd;
   logic          nfc_done;

   logic [3:0]    req_ready_a, rsp_done_a;
   logic [32:0]   nfc_cmd_a;
   logic          nfc_cmd_valid_a, busy_a, init_done_a, timeout_err_a;
   logic [1:0]    grant_id_a;

   logic [3:0]    req_ready_w, rsp_done_w;
   logic [32:0]   nfc_cmd_w;
   logic          nfc_cmd_valid_w, busy_w, init_done_w, timeout_err_w;
   logic [1:0]    grant_id_w;

   int            n_tests = 0;
   int            n_fail  = 0;
   exp_t          q[$];

   always #5 clk = ~clk;

   nfc_cmd_arbiter #(.NREQ(4)) dut_a (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_a),
      .req_cmd(req_cmd), .rsp_done(rsp_done_a), .nfc_cmd(nfc_cmd_a),
      .nfc_cmd_valid(nfc_cmd_valid_a), .nfc_done(nfc_done),
      .grant_id(grant_id_a), .busy(busy_a), .init_done(init_done_a),
      .timeout_err(timeout_err_a)
   );

   nfc_cmd_arbiter #(.NREQ(4), .TIMEOUT(16), .TW(20)) dut_w (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_w),
      .req_cmd(req_cmd), .rsp_done(rsp_done_w), .nfc_cmd(nfc_cmd_w),
      .nfc_cmd_valid(nfc_cmd_valid_w), .nfc_done(nfc_done),
      .grant_id(grant_id_w), .busy(busy_w), .init_done(init_done_w),
      .timeout_err(timeout_err_w)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_a(input string tag);
      chk({tag, "_rsp"},   64'(rsp_done_a), 64'd0);
      chk({tag, "_cmd"},   64'(nfc_cmd_a), 64'd0);
      chk({tag, "_vld"},   64'(nfc_cmd_valid_a), 64'd0);
      chk({tag, "_gid"},   64'(grant_id_a), 64'd0);
      chk({tag, "_busy"},  64'(busy_a), 64'd0);
      chk({tag, "_init"},  64'(init_done_a), 64'd0);
      chk({tag, "_terr"},  64'(timeout_err_a), 64'd0);
      chk({tag, "_ready"}, 64'(req_ready_a), 64'hF);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_valid = '0;
      nfc_done = 1'b0;
      tick();
      tick();
      q.delete();
      rst = 1'b0;
   endtask

   task automatic init_pulse(input string tag);
      nfc_done = 1'b1;
      tick();
      nfc_done = 1'b0;
      chk({tag, "_init_done"}, 64'(init_done_a), 64'd1);
   endtask

   task automatic submit(input int p, input logic [32:0] c, input bit exp_grant);
      exp_t e;
      chk($sformatf("submit%0d_ready", p), 64'(req_ready_a[p]), 64'd1);
      req_cmd[33*p +: 33] = c;
      req_valid[p] = 1'b1;
      if (exp_grant) begin
         e.port = 2'(p);
         e.cmd  = c;
         q.push_back(e);
      end
      tick();
      req_valid[p] = 1'b0;
   endtask

   task automatic grant_check(input string tag, input int exp_wait);
      int   waited;
      exp_t e;
      waited = 0;
      while (!nfc_cmd_valid_a && waited < 64) begin
         tick();
         waited++;
      end
      chk({tag, "_granted"}, 64'(nfc_cmd_valid_a), 64'd1);
      if (!nfc_cmd_valid_a) return;
      chk({tag, "_sb_nonempty"}, 64'(q.size() > 0), 64'd1);
      if (q.size() == 0) return;
      e = q.pop_front();
      chk({tag, "_latency"}, 64'(waited), 64'(exp_wait));
      chk({tag, "_gid"}, 64'(grant_id_a), 64'(e.port));
      chk({tag, "_cmd"}, 64'(nfc_cmd_a), 64'(e.cmd));
      chk({tag, "_busy"}, 64'(busy_a), 64'd1);
   endtask

   task automatic complete(input int p, input int ncyc, input string tag);
      for (int i = 1; i < ncyc; i++) tick();
      chk({tag, "_rsp_idle"}, 64'(rsp_done_a), 64'd0);
      nfc_done = 1'b1;
      tick();
      nfc_done = 1'b0;
      chk({tag, "_rsp"}, 64'(rsp_done_a), 64'(4'b0001 << p));
      chk({tag, "_vld_low"}, 64'(nfc_cmd_valid_a), 64'd0);
      chk({tag, "_ready"}, 64'(req_ready_a[p]), 64'd1);
      tick();
      chk({tag, "_rsp_one"}, 64'(rsp_done_a), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: observed stuck required finish");
      $fatal(1, "bench time limit exceeded");
   end

   initial begin
      logic [32:0] c_hold_a, c_hold_b;
      rst = 1'b1;
      req_valid = '0;
      req_cmd = '0;
      nfc_done = 1'b0;
      tick();
      tick();

      // ---- reset values
      check_reset_a("rst0");
      chk("rst0_w_init", 64'(init_done_w), 64'd0);
      chk("rst0_w_vld", 64'(nfc_cmd_valid_w), 64'd0);
      chk("rst0_w_ready", 64'(req_ready_w), 64'hF);
      rst = 1'b0;

      // ---- single port after init pulse at cycle 10
      for (int c = 1; c < 10; c++) tick();
      chk("p1_pre_init", 64'(init_done_a), 64'd0);
      init_pulse("p1");
      chk("p1_idle_vld", 64'(nfc_cmd_valid_a), 64'd0);
      submit(1, 33'h1_0000_4085, 1'b1);
      chk("p1_ready_low", 64'(req_ready_a[1]), 64'd0);
      grant_check("p1", 1);
      complete(1, 6, "p1");

      // ---- command queued during INIT
      do_reset();
      submit(0, 33'h0_1234_5678, 1'b1);
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("preinit_vld", 64'(nfc_cmd_valid_a), 64'd0);
      end
      init_pulse("preinit");
      chk("preinit_vld_at_init", 64'(nfc_cmd_valid_a), 64'd0);
      grant_check("preinit", 1);
      complete(0, 4, "preinit");

      // ---- round robin with all four pending, ptr = 0
      do_reset();
      init_pulse("rr");
      for (int p = 0; p < 4; p++) begin
         exp_t e;
         e.port = 2'(p);
         e.cmd  = {1'b0, 32'hA000_0000 + 32'(p * 32'h0101)};
         req_cmd[33*p +: 33] = e.cmd;
         q.push_back(e);
      end
      req_valid = 4'hF;
      tick();
      req_valid = '0;
      grant_check("rr0", 1);
      complete(0, 20, "rr0");
      grant_check("rr1", 0);
      submit(0, 33'h1_5555_AAAA, 1'b1);
      complete(1, 19, "rr1");
      grant_check("rr2", 0);
      complete(2, 20, "rr2");
      grant_check("rr3", 0);
      complete(3, 20, "rr3");
      grant_check("rr0b", 0);
      complete(0, 20, "rr0b");

      // ---- holding register isolates a busy port from input changes
      c_hold_a = 33'h1_0F0F_3C3C;
      c_hold_b = 33'h0_DEAD_BEEF;
      submit(2, c_hold_a, 1'b1);
      grant_check("hold", 1);
      req_cmd[66 +: 33] = c_hold_b;
      req_valid[2] = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("hold_cmd_stable", 64'(nfc_cmd_a), 64'(c_hold_a));
         chk("hold_ready_low", 64'(req_ready_a[2]), 64'd0);
      end
      req_valid[2] = 1'b0;
      complete(2, 3, "hold");
      chk("hold_cmd_kept", 64'(nfc_cmd_a), 64'(c_hold_a));
      chk("sb_drained", 64'(q.size()), 64'd0);

      // ---- watchdog expiry, no nfc_done (dut_w)
      do_reset();
      init_pulse("wd1");
      submit(3, 33'h1_2222_3333, 1'b1);
      grant_check("wd1", 1);
      chk("wd1_w_vld", 64'(nfc_cmd_valid_w), 64'd1);
      chk("wd1_w_gid", 64'(grant_id_w), 64'd3);
      for (int c = 1; c < 16; c++) tick();
      chk("wd1_terr_early", 64'(timeout_err_w), 64'd0);
      chk("wd1_vld_early", 64'(nfc_cmd_valid_w), 64'd1);
      tick();
      chk("wd1_terr", 64'(timeout_err_w), 64'd1);
      chk("wd1_vld_low", 64'(nfc_cmd_valid_w), 64'd0);
      chk("wd1_ready_low", 64'(req_ready_w), 64'd0);
      chk("wd1_busy_low", 64'(busy_w), 64'd0);
      chk("wd1_cmd_kept", 64'(nfc_cmd_w), 64'h1_2222_3333);
      nfc_done = 1'b1;
      tick();
      nfc_done = 1'b0;
      chk("wd1_late_done_rsp", 64'(rsp_done_w), 64'd0);
      req_valid[0] = 1'b1;
      tick();
      tick();
      req_valid[0] = 1'b0;
      tick();
      chk("wd1_halt_vld", 64'(nfc_cmd_valid_w), 64'd0);
      chk("wd1_halt_ready", 64'(req_ready_w), 64'd0);
      chk("wd1_halt_terr", 64'(timeout_err_w), 64'd1);

      // ---- nfc_done in the expiry cycle completes normally (dut_w)
      do_reset();
      init_pulse("wd2");
      submit(1, 33'h0_7777_0001, 1'b1);
      grant_check("wd2", 1);
      for (int c = 1; c < 16; c++) tick();
      nfc_done = 1'b1;
      tick();
      nfc_done = 1'b0;
      chk("wd2_terr", 64'(timeout_err_w), 64'd0);
      chk("wd2_rsp", 64'(rsp_done_w), 64'h2);
      chk("wd2_vld_low", 64'(nfc_cmd_valid_w), 64'd0);
      tick();
      chk("wd2_ready", 64'(req_ready_w), 64'hF);
      chk("wd2_rsp_one", 64'(rsp_done_w), 64'd0);

      // ---- reset while busy with three pending
      do_reset();
      init_pulse("mid");
      for (int p = 0; p < 3; p++) begin
         exp_t e;
         e.port = 2'(p);
         e.cmd  = {1'b1, 32'hC000_0000 + 32'(p)};
         req_cmd[33*p +: 33] = e.cmd;
         q.push_back(e);
      end
      req_valid = 4'b0111;
      tick();
      req_valid = '0;
      grant_check("mid", 1);
      tick();
      tick();
      rst = 1'b1;
      #1;
      check_reset_a("mid_rst");
      q.delete();
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("mid_rst_rsp", 64'(rsp_done_a), 64'd0);
      end
      rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("mid_after_rsp", 64'(rsp_done_a), 64'd0);
         chk("mid_after_vld", 64'(nfc_cmd_valid_a), 64'd0);
      end
      chk("mid_after_ready", 64'(req_ready_a), 64'hF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
